// File: rtl/btn_debounce.sv
// btn_debounce: synchronises and debounces active-low push-buttons, producing
// clean active-high levels and one-cycle press/release pulses per channel.
// Optional auto-repeat pulses are built only when BTN_AUTOREPEAT_EN is defined;
// otherwise btn_repeat is tied low and no repeat timers exist.
module btn_debounce #(
  parameter int N_BTN        = 5,
  parameter int DB_CYCLES    = 500000,
  parameter int CNT_W        = 19,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_pressed
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Elaboration-time sanity check of the configuration.
  if ((DB_CYCLES < 2) || (REPEAT_DELAY < 1) || (REPEAT_RATE < 1) ||
      ((CNT_W < 31) && ((32'd1 << CNT_W) <= DB_CYCLES))) begin : g_cfg_check
    $error("btn_debounce: illegal parameter combination");
  end

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;
  logic [N_BTN-1:0] pressed_s;
  logic [CNT_W-1:0] cnt_r     [N_BTN];
  logic [CNT_W-1:0] cnt_nxt_s [N_BTN];
  logic [N_BTN-1:0] level_nxt_s;
  logic [N_BTN-1:0] rise_s;
  logic [N_BTN-1:0] fall_s;

  // Two-flop synchroniser; reset to the released (high) pin state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= {N_BTN{1'b1}};
      sync2_r <= {N_BTN{1'b1}};
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Pins are active-low; internal polarity is 1 = pressed.
  assign pressed_s = ~sync2_r;

  // Per-channel debounce: count consecutive disagreeing cycles, accept on the last.
  always_comb begin
    level_nxt_s = btn_level;
    rise_s      = {N_BTN{1'b0}};
    fall_s      = {N_BTN{1'b0}};
    for (int i = 0; i < N_BTN; i++) begin
      cnt_nxt_s[i] = CNT_ZERO;
      if (pressed_s[i] == btn_level[i]) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] != CNT_LAST) begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end else begin
        cnt_nxt_s[i]   = CNT_ZERO;
        level_nxt_s[i] = pressed_s[i];
        rise_s[i]      = pressed_s[i];
        fall_s[i]      = ~pressed_s[i];
      end
    end
  end

  // Debounce state and registered level/edge outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      btn_level   <= {N_BTN{1'b0}};
      btn_press   <= {N_BTN{1'b0}};
      btn_release <= {N_BTN{1'b0}};
      any_pressed <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      btn_level   <= level_nxt_s;
      btn_press   <= rise_s;
      btn_release <= fall_s;
      any_pressed <= |level_nxt_s;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_ZERO     = {RPT_W{1'b0}};
  localparam logic [RPT_W-1:0] RPT_ONE      = {{(RPT_W-1){1'b0}}, 1'b1};
  localparam logic [RPT_W-1:0] RPT_DELAY_LD = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RATE_LD  = RPT_W'(REPEAT_RATE - 1);

  logic [RPT_W-1:0] rpt_r     [N_BTN];
  logic [RPT_W-1:0] rpt_nxt_s [N_BTN];
  logic [N_BTN-1:0] rpt_fire_s;

  // Repeat timers count down: loaded on press, reloaded with the rate after
  // each repeat, idle while released; a releasing cycle never repeats.
  always_comb begin
    rpt_fire_s = {N_BTN{1'b0}};
    for (int i = 0; i < N_BTN; i++) begin
      rpt_nxt_s[i] = RPT_ZERO;
      if (rise_s[i]) begin
        rpt_nxt_s[i] = RPT_DELAY_LD;
      end else if (!btn_level[i] || fall_s[i]) begin
        rpt_nxt_s[i] = RPT_ZERO;
      end else if (rpt_r[i] == RPT_ZERO) begin
        rpt_fire_s[i] = 1'b1;
        rpt_nxt_s[i]  = RPT_RATE_LD;
      end else begin
        rpt_nxt_s[i] = rpt_r[i] - RPT_ONE;
      end
    end
  end

  // Repeat timer state and registered repeat pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        rpt_r[i] <= RPT_ZERO;
      end
      btn_repeat <= {N_BTN{1'b0}};
    end else begin
      rpt_r      <= rpt_nxt_s;
      btn_repeat <= rpt_fire_s;
    end
  end
`else
  assign btn_repeat = {N_BTN{1'b0}};
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce (DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3).
// Stimulus pushes expected pulse events; the monitor pops one per observed pulse.
module tb_btn_debounce;

  localparam int NB  = 5;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;
  localparam int LAT = DB + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = 5'h1F;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_repeat;
  logic          any_pressed;

  btn_debounce #(
    .N_BTN(NB), .DB_CYCLES(DB), .CNT_W(19), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] rpt;
    logic [NB-1:0] level;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic push(input int c, input logic [NB-1:0] p, input logic [NB-1:0] r,
                      input logic [NB-1:0] t, input logic [NB-1:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.rpt = t; e.level = l;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse cycle must match the oldest expected event.
  ev_t mon_e;
  always @(negedge clk) begin
    if (!rst && ((btn_press | btn_release | btn_repeat) != 5'h00)) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: cycle %0d press %b release %b repeat %b, none expected",
                 cyc, btn_press, btn_release, btn_repeat);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_cycle", cyc, mon_e.cyc);
        check("event_press", 32'(btn_press), 32'(mon_e.press));
        check("event_release", 32'(btn_release), 32'(mon_e.rel));
        check("event_repeat", 32'(btn_repeat), 32'(mon_e.rpt));
        check("event_level", 32'(btn_level), 32'(mon_e.level));
        check("event_any", 32'(any_pressed), 32'(|mon_e.level));
      end
    end
  end

  int t6;

  initial begin
    // 1: reset with all buttons released, then idle
    rst = 1'b1;
    btn = 5'h1F;
    repeat (5) @(negedge clk);
    check("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_repeat, any_pressed}), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_outputs", 32'({btn_level, any_pressed}), 32'd0);

    // 2: clean press on channel 0
    btn[0] = 1'b0;
    push(cyc + LAT, 5'b00001, 5'b00000, 5'b00000, 5'b00001);
    repeat (10) @(negedge clk);
    check("t2_level", 32'(btn_level), 32'h01);
    check("t2_any", 32'(any_pressed), 32'd1);

    // 3: channel 1 bounces with 2-cycle phases, then settles pressed
    for (int i = 0; i < 10; i++) begin
      btn[1] = ~btn[1];
      repeat (2) @(negedge clk);
    end
    btn[1] = 1'b0;
    push(cyc + LAT, 5'b00010, 5'b00000, 5'b00000, 5'b00011);
    repeat (10) @(negedge clk);

    // 4: a 3-cycle glitch on channel 2 is one short of acceptance
    btn[2] = 1'b0;
    repeat (3) @(negedge clk);
    btn[2] = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_level", 32'(btn_level), 32'h03);

    // 5: release on channel 0 and press on channel 3 together
    btn[0] = 1'b1;
    btn[3] = 1'b0;
    push(cyc + LAT, 5'b01000, 5'b00001, 5'b00000, 5'b01010);
    repeat (10) @(negedge clk);

    // release the remaining buttons together
    btn[1] = 1'b1;
    btn[3] = 1'b1;
    push(cyc + LAT, 5'b00000, 5'b01010, 5'b00000, 5'b00000);
    repeat (10) @(negedge clk);
    check("all_released", 32'({btn_level, any_pressed}), 32'd0);

    // 6: reset while channel 4 counter is at 2, button held through reset
    btn[4] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_midcount", 32'({btn_level, btn_press, btn_release, btn_repeat, any_pressed}), 32'd0);
    rst = 1'b0;
    t6 = cyc + LAT;
    push(t6, 5'b10000, 5'b00000, 5'b00000, 5'b10000);
`ifdef BTN_AUTOREPEAT_EN
    push(t6 + RD,          5'b00000, 5'b00000, 5'b10000, 5'b10000);
    push(t6 + RD + RR,     5'b00000, 5'b00000, 5'b10000, 5'b10000);
    push(t6 + RD + 2 * RR, 5'b00000, 5'b00000, 5'b10000, 5'b10000);
`endif
    // release timed so the level drops exactly when a repeat would fire
    repeat (LAT + RD + RR) @(negedge clk);
    btn[4] = 1'b1;
    push(cyc + LAT, 5'b00000, 5'b10000, 5'b00000, 5'b00000);
    repeat (15) @(negedge clk);
    check("t6_level", 32'({btn_level, any_pressed}), 32'd0);

    // drain: every expected event must have been observed
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: %0d expected pulses never seen, first due at cycle %0d",
               exp_q.size(), exp_q[0].cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
